// File: rtl/ahbl_sram_slave.sv
// ahbl_sram_slave: AHB-Lite single-port SRAM slave for the core data bus.
// Byte/half/word transfers, byte-lane writes, WAIT_CYCLES data-phase wait states,
// write-to-read forwarding for back-to-back accesses, two-cycle ERROR for illegal
// transfers. The macro AHBL_SRAM_INIT_EN enables the INIT_FILE parameter check.
module ahbl_sram_slave #(
    parameter int    ADDR_W      = 16,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata
);
    localparam int AW = ADDR_W - 2;
    localparam int DEPTH = 2 ** AW;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_wait_cnt;
    logic [AW-1:0]  r_addr;
    logic [3:0]     r_strb;
    logic           r_write;
    logic [31:0]    r_hrdata;
    logic [31:0]    r_mem [DEPTH];

    logic           w_acc;
    logic           w_legal;
    logic [3:0]     w_strb;
    logic           w_done;
    logic           w_wr_commit;
    logic           w_rd_en;
    logic [AW-1:0]  w_rd_addr;
    logic [31:0]    w_rd_word;
    logic           w_unused;

    // Only NONSEQ/SEQ matter, so htrans[0] carries no information here.
    assign w_unused = htrans[0];

    // Final (ready) cycle of an OKAY data phase.
    assign w_done      = (r_state == S_DATA) && (r_wait_cnt == WAIT_LAST);
    assign w_wr_commit = w_done && r_write;
    // hreadyout depends only on state, so using it here creates no comb loop.
    assign w_acc       = hsel && htrans[1] && hready && hreadyout;

    // Legality and byte-lane decode of the address-phase request.
    always_comb begin
        w_legal = 1'b0;
        w_strb  = 4'b0000;
        case (hsize)
            3'd0: begin
                w_legal = 1'b1;
                w_strb  = 4'b0001 << haddr[1:0];
            end
            3'd1: begin
                w_legal = ~haddr[0];
                w_strb  = haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                w_legal = (haddr[1:0] == 2'b00);
                w_strb  = 4'b1111;
            end
            default: begin
                w_legal = 1'b0;
                w_strb  = 4'b0000;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic: IDLE, the last DATA cycle and ERR2 may all take a new transfer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_acc) w_state_next = w_legal ? S_DATA : S_ERR1;
            S_DATA: begin
                if (w_done) begin
                    if (w_acc) w_state_next = w_legal ? S_DATA : S_ERR1;
                    else       w_state_next = S_IDLE;
                end
            end
            S_ERR1: w_state_next = S_ERR2;
            S_ERR2: begin
                if (w_acc) w_state_next = w_legal ? S_DATA : S_ERR1;
                else       w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus response outputs decoded from state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (r_state)
            S_DATA: hreadyout = w_done;
            S_ERR1: begin hreadyout = 1'b0; hresp = 1'b1; end
            S_ERR2: begin hreadyout = 1'b1; hresp = 1'b1; end
            default: begin hreadyout = 1'b1; hresp = 1'b0; end
        endcase
    end

    // Wait-state counter; restarts from zero on every new data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 r_wait_cnt <= 4'd0;
        else if ((r_state == S_DATA) && !w_done) r_wait_cnt <= r_wait_cnt + 4'd1;
        else                                     r_wait_cnt <= 4'd0;
    end

    // Address-phase capture; clearing r_write on reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_strb  <= 4'b0000;
            r_write <= 1'b0;
        end else if (w_acc) begin
            r_addr  <= haddr[ADDR_W-1:2];
            r_strb  <= w_strb;
            r_write <= hwrite && w_legal;
        end
    end

    // Zero wait: read at the accept edge using the live address.
    // With wait states: read at the edge entering the final data cycle.
    generate
        if (WAIT_CYCLES == 0) begin : g_rd_zero_wait
            assign w_rd_en   = w_acc && w_legal && !hwrite;
            assign w_rd_addr = haddr[ADDR_W-1:2];
        end else begin : g_rd_waited
            assign w_rd_en   = (r_state == S_DATA) && !r_write &&
                               (r_wait_cnt == 4'(WAIT_CYCLES - 1));
            assign w_rd_addr = r_addr;
        end
    endgenerate

    // Per-byte forwarding of a write committing on the same edge to the same word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fwd
            assign w_rd_word[8*gi +: 8] =
                (w_wr_commit && r_strb[gi] && (r_addr == w_rd_addr)) ?
                hwdata[8*gi +: 8] : r_mem[w_rd_addr][8*gi +: 8];
        end
    endgenerate

    // Read data register; holds between read data phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_hrdata <= 32'h0;
        else if (w_rd_en) r_hrdata <= w_rd_word;
    end

    assign hrdata = r_hrdata;

    // Memory array: lane writes at the edge ending a write data phase; never reset.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) r_mem[r_addr][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

`ifdef AHBL_SRAM_INIT_EN
    initial begin
        if (INIT_FILE == "") $fatal(1, "ahbl_sram_slave: INIT_FILE is empty");
    end
`else
    localparam bit p_unused_init = (INIT_FILE == "");
`endif

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: a zero-wait instance and a two-wait instance.
module tb_ahbl_sram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel_b = 1'b0;
    logic [15:0] haddr = '0;
    logic [1:0]  htrans = 2'd0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [31:0] hwdata = '0;
    logic        tgt = 1'b0;

    logic        ro0, rp0, ro1, rp1;
    logic [31:0] rd0, rd1;
    logic        cur_ready, cur_resp;
    logic [31:0] cur_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign cur_ready = tgt ? ro1 : ro0;
    assign cur_resp  = tgt ? rp1 : rp0;
    assign cur_rdata = tgt ? rd1 : rd0;

    ahbl_sram_slave #(.ADDR_W(16), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .hsel(hsel_b && !tgt), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro0),
        .hreadyout(ro0), .hresp(rp0), .hrdata(rd0));

    ahbl_sram_slave #(.ADDR_W(16), .WAIT_CYCLES(2), .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .hsel(hsel_b && tgt), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro1),
        .hreadyout(ro1), .hresp(rp1), .hrdata(rd1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [15:0] a, input logic w, input logic [2:0] sz);
        hsel_b = 1'b1; haddr = a; htrans = 2'd2; hwrite = w; hsize = sz;
    endtask

    task automatic set_idle();
        hsel_b = 1'b0; htrans = 2'd0; hwrite = 1'b0;
    endtask

    // One complete transfer with an idle bus behind it; waits is bounded at 20.
    task automatic xfer(input logic [15:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int waits, output logic resp);
        set_addr(a, w, sz);
        step();
        set_idle();
        hwdata = wd;
        waits = 0;
        while (cur_ready !== 1'b1 && waits < 20) begin
            step();
            waits++;
        end
        rd = cur_rdata;
        resp = cur_resp;
        $display("xfer dut=%0d a=%h w=%0d sz=%0d wd=%h rd=%h waits=%0d resp=%0d",
                 tgt, a, w, sz, wd, rd, waits, resp);
        step();
    endtask

    // Zero-wait write immediately followed by a read address phase.
    task automatic b2b(input logic [15:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                       input logic [15:0] ra, output logic [31:0] rd, output logic rdy);
        set_addr(wa, 1'b1, wsz);
        step();
        hwdata = wd;
        set_addr(ra, 1'b0, 3'd2);
        step();
        set_idle();
        rd = cur_rdata;
        rdy = cur_ready;
        $display("b2b wa=%h wd=%h ra=%h rd=%h", wa, wd, ra, rd);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (ro0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got=%b want=1", ro0); end
        total++; if (rp0 !== 1'b0) begin bad++; $display("FAIL reset_resp0 got=%b want=0", rp0); end
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rdata0 got=%h want=0", rd0); end
        total++; if (ro1 !== 1'b1 || rp1 !== 1'b0 || rd1 !== 32'h0) begin
            bad++; $display("FAIL reset_dut1 got=%b/%b/%h want=1/0/0", ro1, rp1, rd1); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; int w; logic rs;
        tgt = 1'b0;
        xfer(16'h0010, 1'b1, 3'd2, 32'hDEADBEEF, rd, w, rs);
        total++; if (w !== 0 || rs !== 1'b0) begin bad++; $display("FAIL t1_write waits=%0d resp=%b want 0/0", w, rs); end
        xfer(16'h0010, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_read got=%h want=deadbeef", rd); end
        total++; if (w !== 0 || rs !== 1'b0) begin bad++; $display("FAIL t1_read_resp waits=%0d resp=%b want 0/0", w, rs); end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; int w; logic rs;
        xfer(16'h0013, 1'b1, 3'd0, 32'hAA000000, rd, w, rs);
        xfer(16'h0010, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'hAAADBEEF) begin bad++; $display("FAIL t2_byte got=%h want=aaadbeef", rd); end
        xfer(16'h0010, 1'b1, 3'd1, 32'h00005555, rd, w, rs);
        xfer(16'h0010, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'hAAAD5555) begin bad++; $display("FAIL t2_half got=%h want=aaad5555", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int w; logic rs; logic rdy;
        b2b(16'h0020, 3'd2, 32'h12345678, 16'h0020, rd, rdy);
        total++; if (rd !== 32'h12345678 || rdy !== 1'b1) begin
            bad++; $display("FAIL t3_fwd got=%h/%b want=12345678/1", rd, rdy); end
        xfer(16'h0024, 1'b1, 3'd2, 32'h0BADF00D, rd, w, rs);
        b2b(16'h0020, 3'd2, 32'hCAFEF00D, 16'h0024, rd, rdy);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL t3_other_word got=%h want=0badf00d", rd); end
        b2b(16'h0021, 3'd0, 32'h00007700, 16'h0020, rd, rdy);
        total++; if (rd !== 32'hCAFE770D) begin bad++; $display("FAIL t3_byte_fwd got=%h want=cafe770d", rd); end
    endtask

    task automatic test_error();
        logic [31:0] rd; int w; logic rs;
        set_addr(16'h0021, 1'b1, 3'd1);
        step();
        set_idle();
        hwdata = 32'hFFFFFFFF;
        total++; if (ro0 !== 1'b0 || rp0 !== 1'b1) begin bad++; $display("FAIL t4_err1 got=%b/%b want=0/1", ro0, rp0); end
        step();
        total++; if (ro0 !== 1'b1 || rp0 !== 1'b1) begin bad++; $display("FAIL t4_err2 got=%b/%b want=1/1", ro0, rp0); end
        total++; if (rd0 !== 32'hCAFE770D) begin bad++; $display("FAIL t4_hold got=%h want=cafe770d", rd0); end
        step();
        $display("err half a=0021 done");
        total++; if (ro0 !== 1'b1 || rp0 !== 1'b0) begin bad++; $display("FAIL t4_idle got=%b/%b want=1/0", ro0, rp0); end
        xfer(16'h0020, 1'b1, 3'd3, 32'hFFFFFFFF, rd, w, rs);
        total++; if (w !== 1 || rs !== 1'b1) begin bad++; $display("FAIL t4_size3 waits=%0d resp=%b want 1/1", w, rs); end
        xfer(16'h0020, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'hCAFE770D) begin bad++; $display("FAIL t4_unchanged got=%h want=cafe770d", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; int w; logic rs;
        tgt = 1'b1;
        xfer(16'h0010, 1'b1, 3'd2, 32'h11223344, rd, w, rs);
        total++; if (w !== 2) begin bad++; $display("FAIL t5_wr_waits got=%0d want=2", w); end
        xfer(16'h0014, 1'b1, 3'd2, 32'h55667788, rd, w, rs);
        xfer(16'h0010, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'h11223344 || w !== 2 || rs !== 1'b0) begin
            bad++; $display("FAIL t5_read got=%h/%0d/%b want=11223344/2/0", rd, w, rs); end
        // Pipelined reads: second address phase held until the first completes.
        set_addr(16'h0010, 1'b0, 3'd2);
        step();
        set_addr(16'h0014, 1'b0, 3'd2);
        total++; if (ro1 !== 1'b0) begin bad++; $display("FAIL t5_p1_w1 got=%b want=0", ro1); end
        step();
        total++; if (ro1 !== 1'b0) begin bad++; $display("FAIL t5_p1_w2 got=%b want=0", ro1); end
        step();
        total++; if (ro1 !== 1'b1 || rd1 !== 32'h11223344) begin
            bad++; $display("FAIL t5_p1_data got=%b/%h want=1/11223344", ro1, rd1); end
        step();
        set_idle();
        total++; if (ro1 !== 1'b0) begin bad++; $display("FAIL t5_p2_w1 got=%b want=0", ro1); end
        step();
        total++; if (ro1 !== 1'b0) begin bad++; $display("FAIL t5_p2_w2 got=%b want=0", ro1); end
        step();
        total++; if (ro1 !== 1'b1 || rd1 !== 32'h55667788) begin
            bad++; $display("FAIL t5_p2_data got=%b/%h want=1/55667788", ro1, rd1); end
        $display("pipelined reads 0010,0014 done");
        step();
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; int w; logic rs;
        tgt = 1'b1;
        set_addr(16'h0010, 1'b1, 3'd2);
        step();
        set_idle();
        hwdata = 32'hFFFFFFFF;
        total++; if (ro1 !== 1'b0) begin bad++; $display("FAIL t6_in_wait got=%b want=0", ro1); end
        rst = 1'b1;
        #1;
        total++; if (ro1 !== 1'b1 || rp1 !== 1'b0 || rd1 !== 32'h0) begin
            bad++; $display("FAIL t6_async got=%b/%b/%h want=1/0/0", ro1, rp1, rd1); end
        step();
        rst = 1'b0;
        $display("reset during write a=0010");
        step();
        xfer(16'h0010, 1'b0, 3'd2, 32'h0, rd, w, rs);
        total++; if (rd !== 32'h11223344) begin bad++; $display("FAIL t6_mem_kept got=%h want=11223344", rd); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_back_to_back();
        test_error();
        test_wait_states();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends even if a task stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule
